// File: rtl/buffered_window_fifo_if.sv
// Handshake bundle for buffered_window_fifo: push side, window/pop side and status.
// Flush (and its modport entries) exist only when BUFFERED_WINDOW_FIFO_FLUSH_EN is defined.
interface buffered_window_fifo_if #(
  parameter int DATABITWIDTH = 16,
  parameter int FIFODEPTH    = 32,
  parameter int READWIDTH    = 2
);
  localparam int COUNTBITWIDTH = $clog2(FIFODEPTH + 1);
  localparam int POPBITWIDTH   = $clog2(READWIDTH + 1);

  logic                              InputREQ;
  logic                              InputACK;
  logic [DATABITWIDTH-1:0]           InputData;
  logic                              OutputREQ;
  logic                              OutputACK;
  logic [POPBITWIDTH-1:0]            OutputPopCount;
  logic [READWIDTH*DATABITWIDTH-1:0] OutputData;
  logic [POPBITWIDTH-1:0]            OutputValidCount;
  logic [COUNTBITWIDTH-1:0]          Occupancy;
  logic                              AlmostFull;

`ifdef BUFFERED_WINDOW_FIFO_FLUSH_EN
  logic                              Flush;

  modport master (
    output InputREQ, InputData, OutputACK, OutputPopCount, Flush,
    input  InputACK, OutputREQ, OutputData, OutputValidCount, Occupancy, AlmostFull
  );
  modport slave (
    input  InputREQ, InputData, OutputACK, OutputPopCount, Flush,
    output InputACK, OutputREQ, OutputData, OutputValidCount, Occupancy, AlmostFull
  );
`else
  modport master (
    output InputREQ, InputData, OutputACK, OutputPopCount,
    input  InputACK, OutputREQ, OutputData, OutputValidCount, Occupancy, AlmostFull
  );
  modport slave (
    input  InputREQ, InputData, OutputACK, OutputPopCount,
    output InputACK, OutputREQ, OutputData, OutputValidCount, Occupancy, AlmostFull
  );
`endif
endinterface

// File: rtl/buffered_window_fifo.sv
// Push-one / pop-up-to-READWIDTH FIFO exposing a window of entries starting at the tail.
// Optional Flush input enabled by defining BUFFERED_WINDOW_FIFO_FLUSH_EN.
module buffered_window_fifo #(
  parameter int DATABITWIDTH    = 16,
  parameter int FIFODEPTH       = 32,
  parameter int READWIDTH       = 2,
  parameter int ALMOSTFULLLEVEL = 28
) (
  input logic                    clk,
  input logic                    clk_en,
  input logic                    sync_rst,
  buffered_window_fifo_if.slave  bus
);
  localparam int IDXW = (FIFODEPTH == 1) ? 1 : $clog2(FIFODEPTH);
  localparam int CNTW = $clog2(FIFODEPTH + 1);
  localparam int POPW = $clog2(READWIDTH + 1);
  localparam int SUMW = IDXW + 1;

  logic [DATABITWIDTH-1:0] mem [FIFODEPTH];
  logic [IDXW-1:0]         head, tail;
  logic [CNTW-1:0]         occ;
  logic [POPW-1:0]         valid_cnt, req_cnt, pop_cnt;
  logic                    full, push, pop, flush;

  // Non-power-of-2 safe modular add: the sum never reaches 2*FIFODEPTH.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input logic [SUMW-1:0] inc);
    logic [SUMW-1:0] s;
    s = SUMW'(base) + inc;
    if (s >= SUMW'(FIFODEPTH)) s = s - SUMW'(FIFODEPTH);
    return s[IDXW-1:0];
  endfunction

`ifdef BUFFERED_WINDOW_FIFO_FLUSH_EN
  assign flush = bus.Flush;
`else
  assign flush = 1'b0;
`endif

  assign full      = (occ == CNTW'(FIFODEPTH));
  assign valid_cnt = (occ >= CNTW'(READWIDTH)) ? POPW'(READWIDTH) : occ[POPW-1:0];
  assign req_cnt   = (bus.OutputPopCount == '0) ? POPW'(1) : bus.OutputPopCount;
  assign pop_cnt   = (req_cnt > valid_cnt) ? valid_cnt : req_cnt;

  // Full is judged on registered state only, so a same-cycle pop never frees a slot early.
  assign push = clk_en & bus.InputREQ & ~full;
  assign pop  = clk_en & bus.OutputACK & (occ != '0) & ~flush;

  assign bus.InputACK         = ~full;
  assign bus.OutputREQ        = (occ != '0);
  assign bus.OutputValidCount = valid_cnt;
  assign bus.Occupancy        = occ;
  assign bus.AlmostFull       = (int'(occ) >= ALMOSTFULLLEVEL);

  for (genvar i = 0; i < READWIDTH; i++) begin : g_lane
    logic [IDXW-1:0] idx;
    assign idx = wrap_add(tail, SUMW'(i));
    assign bus.OutputData[i*DATABITWIDTH +: DATABITWIDTH] =
      (POPW'(i) < valid_cnt) ? mem[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (push && !sync_rst) mem[head] <= bus.InputData;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clk_en) begin
      if (push) head <= wrap_add(head, SUMW'(1));
      if (flush) begin
        tail <= head;
        occ  <= CNTW'(push);
      end else begin
        if (pop) tail <= wrap_add(tail, SUMW'(pop_cnt));
        occ <= occ + CNTW'(push) - (pop ? CNTW'(pop_cnt) : '0);
      end
    end
  end
endmodule

// File: tb/tb_buffered_window_fifo.sv
// Bench for buffered_window_fifo: vector table plus queue scoreboard on a 32-deep and a 5-deep instance.
module tb_buffered_window_fifo;
  logic clk = 1'b0, clk_en = 1'b0, sync_rst = 1'b0;
  always #5 clk = ~clk;

  buffered_window_fifo_if #(.DATABITWIDTH(16), .FIFODEPTH(32), .READWIDTH(2)) a ();
  buffered_window_fifo_if #(.DATABITWIDTH(16), .FIFODEPTH(5),  .READWIDTH(2)) b ();

  buffered_window_fifo #(.DATABITWIDTH(16), .FIFODEPTH(32), .READWIDTH(2), .ALMOSTFULLLEVEL(28))
    dut_a (.clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .bus(a));
  buffered_window_fifo #(.DATABITWIDTH(16), .FIFODEPTH(5), .READWIDTH(2), .ALMOSTFULLLEVEL(4))
    dut_b (.clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .bus(b));

  int checks = 0, failures = 0;
  logic [15:0] qa[$], qb[$];

  typedef struct {
    bit rst, req, ack; logic [15:0] d; logic [1:0] pc;
    int occ, vc; logic [31:0] data;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a.InputREQ = 0; a.InputData = '0; a.OutputACK = 0; a.OutputPopCount = '0;
    b.InputREQ = 0; b.InputData = '0; b.OutputACK = 0; b.OutputPopCount = '0;
`ifdef BUFFERED_WINDOW_FIFO_FLUSH_EN
    a.Flush = 0; b.Flush = 0;
`endif
    sync_rst = 0; clk_en = 1;
  endtask

  task automatic check_a();
    int n = qa.size();
    chk("a_occ", 64'(a.Occupancy), 64'(n));
    chk("a_vc", 64'(a.OutputValidCount), 64'(n < 2 ? n : 2));
    chk("a_req", 64'(a.OutputREQ), 64'(n != 0));
    chk("a_ack", 64'(a.InputACK), 64'(n != 32));
    chk("a_afull", 64'(a.AlmostFull), 64'(n >= 28));
    for (int i = 0; i < 2; i++)
      chk($sformatf("a_lane%0d", i), 64'(a.OutputData[i*16 +: 16]), 64'(i < n ? qa[i] : 16'h0));
  endtask

  task automatic check_b();
    int n = qb.size();
    chk("b_occ", 64'(b.Occupancy), 64'(n));
    chk("b_ack", 64'(b.InputACK), 64'(n != 5));
    chk("b_afull", 64'(b.AlmostFull), 64'(n >= 4));
    for (int i = 0; i < 2; i++)
      chk($sformatf("b_lane%0d", i), 64'(b.OutputData[i*16 +: 16]), 64'(i < n ? qb[i] : 16'h0));
  endtask

  // Model update uses the pre-edge queue: pops take from the front, an accepted push appends.
  task automatic step_a(input bit rst, input bit en, input bit req, input logic [15:0] d,
                        input bit ack, input logic [1:0] pc, input bit fl);
    int vc, p;
    bit push, pop;
    sync_rst = rst; clk_en = en;
    a.InputREQ = req; a.InputData = d; a.OutputACK = ack; a.OutputPopCount = pc;
`ifdef BUFFERED_WINDOW_FIFO_FLUSH_EN
    a.Flush = fl;
`endif
    @(posedge clk); #1;
    if (rst) begin
      qa.delete(); qb.delete();
    end else if (en) begin
      vc = qa.size() < 2 ? qa.size() : 2;
      push = req && qa.size() != 32;
      pop = ack && qa.size() != 0 && !fl;
      p = (pc == 0) ? 1 : int'(pc);
      if (p > vc) p = vc;
      if (fl) qa.delete();
      if (pop) repeat (p) void'(qa.pop_front());
      if (push) qa.push_back(d);
    end
    idle();
    check_a();
  endtask

  task automatic step_b(input bit rst, input bit req, input logic [15:0] d,
                        input bit ack, input logic [1:0] pc);
    int vc, p;
    bit push, pop;
    sync_rst = rst; clk_en = 1;
    b.InputREQ = req; b.InputData = d; b.OutputACK = ack; b.OutputPopCount = pc;
    @(posedge clk); #1;
    if (rst) begin
      qa.delete(); qb.delete();
    end else begin
      vc = qb.size() < 2 ? qb.size() : 2;
      push = req && qb.size() != 5;
      pop = ack && qb.size() != 0;
      p = (pc == 0) ? 1 : int'(pc);
      if (p > vc) p = vc;
      if (pop) repeat (p) void'(qb.pop_front());
      if (push) qb.push_back(d);
    end
    idle();
    check_b();
  endtask

  initial begin
    idle();
    clk_en = 0;
    //          rst req ack d         pc occ vc data
    vecs[0] = '{1, 0, 0, 16'h0,    0, 0, 0, 32'h0000_0000};
    vecs[1] = '{0, 1, 0, 16'hA001, 0, 1, 1, 32'h0000_A001};
    vecs[2] = '{0, 1, 0, 16'hA002, 0, 2, 2, 32'hA002_A001};
    vecs[3] = '{0, 1, 0, 16'hA003, 0, 3, 2, 32'hA002_A001};
    vecs[4] = '{0, 0, 1, 16'h0,    2, 1, 1, 32'h0000_A003};
    vecs[5] = '{0, 0, 1, 16'h0,    2, 0, 0, 32'h0000_0000};
    vecs[6] = '{0, 1, 1, 16'hA004, 1, 1, 1, 32'h0000_A004};
    vecs[7] = '{0, 1, 0, 16'hA005, 0, 2, 2, 32'hA005_A004};
    vecs[8] = '{0, 0, 1, 16'h0,    0, 1, 1, 32'h0000_A005};
    vecs[9] = '{0, 0, 1, 16'h0,    3, 0, 0, 32'h0000_0000};
    for (int v = 0; v < 10; v++) begin
      step_a(vecs[v].rst, 1, vecs[v].req, vecs[v].d, vecs[v].ack, vecs[v].pc, 0);
      chk($sformatf("vec%0d_occ", v), 64'(a.Occupancy), 64'(vecs[v].occ));
      chk($sformatf("vec%0d_vc", v), 64'(a.OutputValidCount), 64'(vecs[v].vc));
      chk($sformatf("vec%0d_data", v), 64'(a.OutputData), 64'(vecs[v].data));
    end

    // Fill to full, then push+pop while full must only pop.
    for (int i = 0; i < 32; i++) step_a(0, 1, 1, 16'h3000 + 16'(i), 0, 0, 0);
    chk("full_ack", 64'(a.InputACK), 64'(0));
    chk("full_afull", 64'(a.AlmostFull), 64'(1));
    step_a(0, 1, 1, 16'hDEAD, 1, 1, 0);
    chk("full_pushpop_occ", 64'(a.Occupancy), 64'(31));
    chk("full_pushpop_lane0", 64'(a.OutputData[15:0]), 64'(16'h3001));
    for (int i = 0; i < 16; i++) step_a(0, 1, 0, 16'h0, 1, 2, 0);
    chk("drained_req", 64'(a.OutputREQ), 64'(0));

    // Reset mid-operation, then clk_en low freezes everything.
    for (int i = 0; i < 7; i++) step_a(0, 1, 1, 16'h5000 + 16'(i), 0, 0, 0);
    step_a(1, 1, 1, 16'h5555, 1, 2, 0);
    chk("rst_occ", 64'(a.Occupancy), 64'(0));
    chk("rst_req", 64'(a.OutputREQ), 64'(0));
    chk("rst_ack", 64'(a.InputACK), 64'(1));
    for (int i = 0; i < 3; i++) step_a(0, 1, 1, 16'h6000 + 16'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 16'h7777, 1, 2, 1);
    chk("frozen_occ", 64'(a.Occupancy), 64'(3));
    chk("frozen_lanes", 64'(a.OutputData), 64'(32'h6001_6000));

    // Depth-5 wrap with alternating pop counts.
    step_b(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) step_b(0, 1, 16'hB000 + 16'(i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      step_b(0, 1, 16'hB100 + 16'(i), 1, (i % 2) ? 2'd2 : 2'd1);
      if (i % 2) step_b(0, 1, 16'hB200 + 16'(i), 0, 0);
    end
    for (int i = 0; i < 4; i++) step_b(0, 0, 16'h0, 1, 1);

`ifdef BUFFERED_WINDOW_FIFO_FLUSH_EN
    step_a(1, 1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step_a(0, 1, 1, 16'h8000 + 16'(i), 0, 0, 0);
    step_a(0, 1, 1, 16'hBEEF, 1, 1, 1);
    chk("flush_occ", 64'(a.Occupancy), 64'(1));
    chk("flush_lane0", 64'(a.OutputData[15:0]), 64'(16'hBEEF));
    step_a(0, 1, 1, 16'hC001, 0, 0, 0);
    step_a(0, 1, 0, 16'h0, 1, 2, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
